if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of fetch entries buffered; legal values 2, 4, 8.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  redirect from branch/jump resolution; discards all buffered and incoming fetches.
REQ-005 SHALL have port imem_resp  input  1  instruction memory response valid this cycle.
REQ-006 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-007 SHALL have port req_pc  input  32  PC of the fetch completing this cycle.
REQ-008 SHALL have port id_ready  input  1  decode accepts the head entry this cycle.
REQ-009 SHALL have port id_valid  output  1  head entry present for decode.
REQ-010 SHALL have port id_pc  output  32  head entry PC.
REQ-011 SHALL have port id_instr  output  32  head entry instruction.
REQ-012 SHALL have port ifq_full  output  1  no free entry; fetch stage deasserts load_pc.
REQ-013 SHALL have port ifq_count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-014 SHALL be a circular FIFO of {pc, instr} entries, head/tail pointers $clog2(DEPTH) bits wrapping DEPTH-1 -> 0.
REQ-015 SHALL enqueue {req_pc, imem_rdata} at tail when imem_resp && !flush && (!ifq_full || deq).
REQ-016 SHALL dequeue head when deq = id_valid && id_ready && !flush.
REQ-017 SHALL on simultaneous enqueue and dequeue keep ifq_count unchanged, including when full (full-throughput).
REQ-018 SHALL silently drop imem_resp arriving while full with no dequeue; state unchanged.
REQ-019 SHALL on flush set count 0, head = tail = 0 at next edge, ignoring same-cycle imem_resp and id_ready.
REQ-020 SHALL drive id_valid = (ifq_count != 0); ifq_full = (ifq_count == DEPTH).
REQ-021 SHALL drive id_pc = 0 and id_instr = 32'h00000013 (NOP) whenever id_valid is 0.
REQ-022 SHALL have minimum latency of one cycle from imem_resp to id_valid (bypass disabled).
REQ-023 SHALL preserve strict fetch order; no entry duplicated or reordered.

Reset
REQ-024 SHALL on rst low immediately clear pointers, count, and storage to 0; id_valid 0, ifq_full 0, id_instr NOP.
REQ-025 SHALL discard in-flight enqueue/dequeue when reset asserts mid-cycle; first enqueue permitted on first edge after release.

Configuration
REQ-026 SHALL support macro IFQ_BYPASS_EN.
REQ-027 With IFQ_BYPASS_EN defined: when empty, imem_resp high and flush low, id_valid/id_pc/id_instr SHALL reflect the incoming response combinationally; if id_ready also high, entry SHALL not be written (zero-latency pass-through).
REQ-028 Without IFQ_BYPASS_EN: outputs SHALL come only from storage; REQ-022 latency holds.

Structure
REQ-029 SHALL place typedef ifq_entry_t {rv32i_word pc; rv32i_word instr} and constant NOP_INSTR = 32'h00000013 in package rv32i_types.
REQ-030 SHALL implement storage and pointers inline; no sub-module is warranted.

Verification
REQ-031 Reset: rst low with imem_resp high -> id_valid 0, ifq_count 0, id_instr 32'h00000013.
REQ-032 Fill: DEPTH=2, id_ready 0, responses pc 0x60, 0x64 -> ifq_full 1 at edge 2; third response pc 0x68 dropped; drain yields 0x60, 0x64 in order.
REQ-033 Full throughput: full, imem_resp pc 0x68 with id_ready 1 -> 0x60 consumed, count stays 2, later outputs 0x64, 0x68.
REQ-034 Flush: 2 entries, flush with imem_resp pc 0x70 -> next cycle id_valid 0, count 0; 0x70 never appears.
REQ-035 Wrap: DEPTH=4, 10 back-to-back responses pc 0x00..0x24 with id_ready toggling -> exact in-order sequence, no loss.
REQ-036 Bypass: IFQ_BYPASS_EN, empty, imem_resp pc 0x80 with id_ready 1 -> id_valid 1, id_pc 0x80 same cycle, count stays 0; without macro id_valid rises next cycle.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared RV32I types for the fetch/decode boundary: word type, queue entry, NOP encoding.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } ifq_entry_t;

    // addi x0, x0, 0
    localparam rv32i_word NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle around the IF/ID queue; master = fetch+decode side, slave = queue.
interface if_id_queue_if
    import rv32i_types::*;
#(
    parameter int DEPTH = 2
) ();

    logic                     flush;
    logic                     imem_resp;
    rv32i_word                imem_rdata;
    rv32i_word                req_pc;
    logic                     id_ready;
    logic                     id_valid;
    rv32i_word                id_pc;
    rv32i_word                id_instr;
    logic                     ifq_full;
    logic [$clog2(DEPTH):0]   ifq_count;

    modport master (
        output flush, imem_resp, imem_rdata, req_pc, id_ready,
        input  id_valid, id_pc, id_instr, ifq_full, ifq_count
    );

    modport slave (
        input  flush, imem_resp, imem_rdata, req_pc, id_ready,
        output id_valid, id_pc, id_instr, ifq_full, ifq_count
    );

endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: circular FIFO of {pc, instr} between fetch and decode.
// Optional zero-latency pass-through when empty is enabled with IFQ_BYPASS_EN.
module if_id_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   imem_resp,
    input  rv32i_word              imem_rdata,
    input  rv32i_word              req_pc,
    input  logic                   id_ready,
    output logic                   id_valid,
    output rv32i_word              id_pc,
    output rv32i_word              id_instr,
    output logic                   ifq_full,
    output logic [$clog2(DEPTH):0] ifq_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ifq_entry_t         r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_deq;
    logic w_enq;
    logic w_bypass_hit;
    logic w_bypass_take;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));

    // A storage dequeue needs a stored head; a pass-through word is never stored.
    assign w_deq = !w_empty && id_ready && !flush;

`ifdef IFQ_BYPASS_EN
    assign w_bypass_hit = rst && w_empty && imem_resp && !flush;
`else
    assign w_bypass_hit = 1'b0;
`endif
    assign w_bypass_take = w_bypass_hit && id_ready;

    assign w_enq = imem_resp && !flush && (!w_full || w_deq) && !w_bypass_take;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            // NOTE: storage is reset too, so a cleared queue can never expose stale words.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_mem[r_tail] <= '{pc: req_pc, instr: imem_rdata};
                r_tail        <= r_tail + PTR_W'(1);
            end
            if (w_deq) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
        end
    end

    // NOTE: every output gets a default first so this block cannot infer a latch.
    always_comb begin
        id_valid = 1'b0;
        id_pc    = '0;
        id_instr = NOP_INSTR;
        if (!w_empty) begin
            id_valid = 1'b1;
            id_pc    = r_mem[r_head].pc;
            id_instr = r_mem[r_head].instr;
        end else if (w_bypass_hit) begin
            id_valid = 1'b1;
            id_pc    = req_pc;
            id_instr = imem_rdata;
        end
    end

    assign ifq_full  = w_full;
    assign ifq_count = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: DEPTH=2 and DEPTH=4 instances checked against a queue model.
module tb_if_id_queue;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    if_id_queue_if #(.DEPTH(2)) b2 ();
    if_id_queue_if #(.DEPTH(4)) b4 ();

    if_id_queue #(.DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .flush(b2.flush), .imem_resp(b2.imem_resp),
        .imem_rdata(b2.imem_rdata), .req_pc(b2.req_pc), .id_ready(b2.id_ready),
        .id_valid(b2.id_valid), .id_pc(b2.id_pc), .id_instr(b2.id_instr),
        .ifq_full(b2.ifq_full), .ifq_count(b2.ifq_count)
    );

    if_id_queue #(.DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .flush(b4.flush), .imem_resp(b4.imem_resp),
        .imem_rdata(b4.imem_rdata), .req_pc(b4.req_pc), .id_ready(b4.id_ready),
        .id_valid(b4.id_valid), .id_pc(b4.id_pc), .id_instr(b4.id_instr),
        .ifq_full(b4.ifq_full), .ifq_count(b4.ifq_count)
    );

`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int         n_pass   = 0;
    int         n_checks = 0;
    ifq_entry_t mq [2][$];
    rv32i_word  consumed [$];
    logic       last_valid;
    rv32i_word  last_pc;

    function automatic rv32i_word instr_of(input rv32i_word pc);
        return pc ^ 32'h5A5A_0000;
    endfunction

    function automatic int depth_of(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic drive(input int d, input bit fl, input bit resp, input rv32i_word pc, input bit rdy);
        if (d == 0) begin
            b2.flush = fl; b2.imem_resp = resp; b2.req_pc = pc;
            b2.imem_rdata = instr_of(pc); b2.id_ready = rdy;
        end else begin
            b4.flush = fl; b4.imem_resp = resp; b4.req_pc = pc;
            b4.imem_rdata = instr_of(pc); b4.id_ready = rdy;
        end
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, '0, 1'b0);
        drive(1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic observe(input int d, output logic v, output rv32i_word pc, output rv32i_word ins,
                           output logic f, output logic [31:0] cnt);
        if (d == 0) begin
            v = b2.id_valid; pc = b2.id_pc; ins = b2.id_instr; f = b2.ifq_full; cnt = 32'(b2.ifq_count);
        end else begin
            v = b4.id_valid; pc = b4.id_pc; ins = b4.id_instr; f = b4.ifq_full; cnt = 32'(b4.ifq_count);
        end
    endtask

    // Check the stable registered view of instance d (called 1ns after an edge with idle inputs).
    task automatic check_state(input int d, input string tag, input bit ev, input rv32i_word epc,
                               input rv32i_word eins, input bit ef, input int ecnt);
        logic v, f; rv32i_word pc, ins; logic [31:0] cnt;
        observe(d, v, pc, ins, f, cnt);
        check({tag, ".valid"}, 32'(v), 32'(ev));
        check({tag, ".pc"}, pc, epc);
        check({tag, ".instr"}, ins, eins);
        check({tag, ".full"}, 32'(f), 32'(ef));
        check({tag, ".count"}, cnt, 32'(ecnt));
    endtask

    // One clock cycle on instance d: outputs checked against the model mid-cycle, model advanced at the edge.
    task automatic cycle(input int d, input bit fl, input bit resp, input rv32i_word pc, input bit rdy);
        logic v, f; rv32i_word opc, oins; logic [31:0] cnt;
        int   size;
        bit   byp, deq, enq, take;
        rv32i_word epc, eins;
        drive(d, fl, resp, pc, rdy);
        @(negedge clk);
        observe(d, v, opc, oins, f, cnt);
        size = mq[d].size();
        byp  = BYP && (size == 0) && resp && !fl;
        epc  = (size != 0) ? mq[d][0].pc    : (byp ? pc : 32'h0);
        eins = (size != 0) ? mq[d][0].instr : (byp ? instr_of(pc) : NOP_INSTR);
        check("cyc.valid", 32'(v), 32'((size != 0) || byp));
        check("cyc.pc", opc, epc);
        check("cyc.instr", oins, eins);
        check("cyc.full", 32'(f), 32'(size == depth_of(d)));
        check("cyc.count", cnt, 32'(size));
        last_valid = v;
        last_pc    = opc;
        if (v && rdy && !fl) consumed.push_back(opc);
        if (fl) begin
            mq[d].delete();
        end else begin
            deq  = (size != 0) && rdy;
            take = byp && rdy;
            enq  = resp && ((size < depth_of(d)) || deq) && !take;
            if (deq) void'(mq[d].pop_front());
            if (enq) mq[d].push_back('{pc: pc, instr: instr_of(pc)});
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        // Reset held with a response present: nothing may be visible or counted.
        rst = 1'b0;
        drive(0, 1'b0, 1'b1, 32'h11, 1'b0);
        drive(1, 1'b0, 1'b1, 32'h11, 1'b0);
        #12;
        check_state(0, "reset2", 1'b0, 32'h0, NOP_INSTR, 1'b0, 0);
        check_state(1, "reset4", 1'b0, 32'h0, NOP_INSTR, 1'b0, 0);
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Fill DEPTH=2, then a third response while full is dropped.
        cycle(0, 1'b0, 1'b1, 32'h60, 1'b0);
        cycle(0, 1'b0, 1'b1, 32'h64, 1'b0);
        check_state(0, "fill", 1'b1, 32'h60, instr_of(32'h60), 1'b1, 2);
        cycle(0, 1'b0, 1'b1, 32'h68, 1'b0);
        check_state(0, "drop", 1'b1, 32'h60, instr_of(32'h60), 1'b1, 2);

        // Full throughput: enqueue and dequeue together while full.
        cycle(0, 1'b0, 1'b1, 32'h68, 1'b1);
        check_state(0, "thru", 1'b1, 32'h64, instr_of(32'h64), 1'b1, 2);
        cycle(0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_state(0, "drain1", 1'b1, 32'h68, instr_of(32'h68), 1'b0, 1);
        cycle(0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_state(0, "drain2", 1'b0, 32'h0, NOP_INSTR, 1'b0, 0);

        // Flush discards buffered entries and the same-cycle response.
        cycle(0, 1'b0, 1'b1, 32'h50, 1'b0);
        cycle(0, 1'b0, 1'b1, 32'h54, 1'b0);
        cycle(0, 1'b1, 1'b1, 32'h70, 1'b1);
        check_state(0, "flush", 1'b0, 32'h0, NOP_INSTR, 1'b0, 0);
        cycle(0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_state(0, "postflush", 1'b0, 32'h0, NOP_INSTR, 1'b0, 0);

        // Response into an empty queue with decode ready.
        cycle(0, 1'b0, 1'b1, 32'h80, 1'b1);
`ifdef IFQ_BYPASS_EN
        check("bypass.same_valid", 32'(last_valid), 32'h1);
        check("bypass.same_pc", last_pc, 32'h80);
        check_state(0, "bypass.after", 1'b0, 32'h0, NOP_INSTR, 1'b0, 0);
`else
        check("nobypass.same_valid", 32'(last_valid), 32'h0);
        check_state(0, "nobypass.next", 1'b1, 32'h80, instr_of(32'h80), 1'b0, 1);
        cycle(0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_state(0, "nobypass.drain", 1'b0, 32'h0, NOP_INSTR, 1'b0, 0);
`endif

        // Wrap on DEPTH=4: ten back-to-back responses, decode ready two cycles in three.
        consumed.delete();
        for (int i = 0; i < 10; i++) cycle(1, 1'b0, 1'b1, 32'(i * 4), (i % 3) != 0);
        for (int k = 0; k < 8 && mq[1].size() != 0; k++) cycle(1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("wrap.n_out", 32'(consumed.size()), 32'd10);
        for (int i = 0; i < 10; i++) check("wrap.order", consumed[i], 32'(i * 4));

        // Reset asserted mid-cycle clears immediately; enqueue allowed on the first edge after release.
        for (int i = 0; i < 3; i++) cycle(1, 1'b0, 1'b1, 32'(32'h100 + i * 4), 1'b0);
        cycle(0, 1'b0, 1'b1, 32'h200, 1'b0);
        #2 rst = 1'b0;
        #1;
        mq[0].delete();
        mq[1].delete();
        check_state(1, "midrst4", 1'b0, 32'h0, NOP_INSTR, 1'b0, 0);
        check_state(0, "midrst2", 1'b0, 32'h0, NOP_INSTR, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 1'b0, 1'b1, 32'h90, 1'b0);
        @(posedge clk);
        #1;
        idle();
        mq[1].push_back('{pc: 32'h90, instr: instr_of(32'h90)});
        check_state(1, "rstrel", 1'b1, 32'h90, instr_of(32'h90), 1'b0, 1);

        // Randomized traffic on both depths against the model.
        for (int i = 0; i < 250; i++) begin
            for (int d = 0; d < 2; d++) begin
                cycle(d, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 70,
                      $urandom & 32'hFFFF_FFFC, $urandom_range(0, 99) < 50);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
